// File: rtl/mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : mips_boot_loader
// Purpose  : Streams a program into instruction memory over valid/ready and
//            holds the MIPS core in reset until the load completes.
//            Optional checksum trailer word: define MIPS_BOOT_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mips_boot_loader #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int RST_HOLD = 4
) (
   input  logic              clk_CPU,
   input  logic              rst,
   input  logic              start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_HOLD  = 3'd2,
      S_RUN   = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] c_LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0] c_ONE      = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [7:0]      c_HOLD     = 8'(RST_HOLD);

   state_t              r_state,      w_state;
   logic                r_loadReady,  w_loadReady;
   logic                r_memWe,      w_memWe;
   logic [ADDR_W-1:0]   r_memAddr,    w_memAddr;
   logic [DATA_W-1:0]   r_memWdata,   w_memWdata;
   logic                r_cpuRst,     w_cpuRst;
   logic                r_done,       w_done;
   logic                r_error,      w_error;
   logic [ADDR_W:0]     r_wordCount,  w_wordCount;
   logic [7:0]          r_holdCnt,    w_holdCnt;
   logic                w_transfer;
`ifdef MIPS_BOOT_CHECKSUM_EN
   logic [DATA_W-1:0]   r_sum,        w_sum;
`endif

   assign w_transfer = load_valid && r_loadReady;

   always_ff @(posedge clk_CPU or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_loadReady <= 1'b0;
         r_memWe     <= 1'b0;
         r_memAddr   <= '0;
         r_memWdata  <= '0;
         r_cpuRst    <= 1'b1;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_wordCount <= '0;
         r_holdCnt   <= '0;
`ifdef MIPS_BOOT_CHECKSUM_EN
         r_sum       <= '0;
`endif
      end else begin
         r_state     <= w_state;
         r_loadReady <= w_loadReady;
         r_memWe     <= w_memWe;
         r_memAddr   <= w_memAddr;
         r_memWdata  <= w_memWdata;
         r_cpuRst    <= w_cpuRst;
         r_done      <= w_done;
         r_error     <= w_error;
         r_wordCount <= w_wordCount;
         r_holdCnt   <= w_holdCnt;
`ifdef MIPS_BOOT_CHECKSUM_EN
         r_sum       <= w_sum;
`endif
      end
   end

   always_comb begin
      w_state     = r_state;
      w_memWe     = 1'b0;
      w_memAddr   = r_memAddr;
      w_memWdata  = r_memWdata;
      w_wordCount = r_wordCount;
      w_holdCnt   = r_holdCnt;
`ifdef MIPS_BOOT_CHECKSUM_EN
      w_sum       = r_sum;
`endif

      case (r_state)
         S_IDLE, S_RUN, S_ERROR: begin
            if (start) w_state = S_LOAD;
         end
         S_LOAD: begin
            if (w_transfer) begin
`ifdef MIPS_BOOT_CHECKSUM_EN
               if (load_last) begin
                  // Checksum word is never written; hold count starts at one so
                  // the release delay still runs from the last data write.
                  w_holdCnt = 8'd1;
                  w_state   = (load_data == r_sum) ? S_HOLD : S_ERROR;
               end else begin
                  w_memWe     = 1'b1;
                  w_memAddr   = r_wordCount[ADDR_W-1:0];
                  w_memWdata  = load_data;
                  w_wordCount = r_wordCount + c_ONE;
                  w_sum       = r_sum + load_data;
                  if (r_wordCount == c_LAST_IDX) w_state = S_ERROR;
               end
`else
               w_memWe     = 1'b1;
               w_memAddr   = r_wordCount[ADDR_W-1:0];
               w_memWdata  = load_data;
               w_wordCount = r_wordCount + c_ONE;
               w_holdCnt   = '0;
               if (load_last)                       w_state = S_HOLD;
               else if (r_wordCount == c_LAST_IDX)  w_state = S_ERROR;
`endif
            end
         end
         S_HOLD: begin
            if (r_holdCnt == c_HOLD) w_state   = S_RUN;
            else                     w_holdCnt = r_holdCnt + 8'd1;
         end
         default: w_state = S_IDLE;
      endcase

      // Every entry into LOAD starts a fresh image.
      if (w_state == S_LOAD && r_state != S_LOAD) begin
         w_wordCount = '0;
`ifdef MIPS_BOOT_CHECKSUM_EN
         w_sum       = '0;
`endif
      end

      w_loadReady = (w_state == S_LOAD);
      w_cpuRst    = (w_state != S_RUN);
      w_done      = (w_state == S_RUN);
      w_error     = (w_state == S_ERROR);
   end

   assign load_ready = r_loadReady;
   assign mem_we     = r_memWe;
   assign mem_addr   = r_memAddr;
   assign mem_wdata  = r_memWdata;
   assign cpu_rst    = r_cpuRst;
   assign done       = r_done;
   assign error      = r_error;
   assign word_count = r_wordCount;

endmodule
`default_nettype wire

// File: tb/tb_mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_boot_loader
// Purpose  : Scoreboard bench for mips_boot_loader with randomized loads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_boot_loader;
   localparam int ADDR_W   = 2;
   localparam int DATA_W   = 32;
   localparam int RST_HOLD = 4;
   localparam int DEPTH    = 1 << ADDR_W;

   logic              clk_CPU = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              load_valid = 1'b0;
   logic [DATA_W-1:0] load_data = '0;
   logic              load_last = 1'b0;
   logic              load_ready, mem_we, cpu_rst, done, error;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [ADDR_W:0]   word_count;

   mips_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_HOLD(RST_HOLD)) dut (
      .clk_CPU(clk_CPU), .rst(rst), .start(start), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst(cpu_rst), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk_CPU = ~clk_CPU;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lastWeCyc = 0;
   int fallCyc = -1;
   logic prevCpuRst = 1'b1;
   logic [ADDR_W-1:0] expA[$];
   logic [DATA_W-1:0] expD[$];

   always @(posedge clk_CPU) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write monitor: every memory write must match the oldest expected write.
   always @(negedge clk_CPU) begin
      if (mem_we === 1'b1) begin
         lastWeCyc = cyc;
         if (expA.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
         end else begin
            check("write_addr", 64'(mem_addr), 64'(expA.pop_front()));
            check("write_data", 64'(mem_wdata), 64'(expD.pop_front()));
         end
      end
      if (cpu_rst === 1'b0 && prevCpuRst === 1'b1) fallCyc = cyc;
      prevCpuRst = cpu_rst;
   end

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk_CPU); #1;
      start = 1'b0;
   endtask

   task automatic sendWord(input logic [DATA_W-1:0] d, input logic last, input int gaps);
      int  guard;
      bit  rdy;
      for (int g = 0; g < gaps; g++) begin
         load_valid = 1'b0;
         @(negedge clk_CPU);
         check("ready_in_gap", 64'(load_ready), 64'd1);
         @(posedge clk_CPU); #1;
      end
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      guard = 0;
      do begin
         @(negedge clk_CPU);
         rdy = load_ready;
         @(posedge clk_CPU); #1;
         guard++;
      end while (!rdy && guard < 20);
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: got load_ready 0 expected 1 within 20 cycles");
      end
   endtask

   // Model: data words land at addresses 0..n-1 in order; load ends in RUN
   // (or ERROR on a bad checksum) with word_count equal to the data words.
   task automatic runLoad(input logic [DATA_W-1:0] words[$], input int maxGap, input bit badSum);
      logic [DATA_W-1:0] sum;
      int gap;
      int n;
      bit settled;
      n = words.size();
      sum = '0;
      fallCyc = -1;
      pulseStart();
      check("wc_cleared", 64'(word_count), 64'd0);
      check("ready_on_load", 64'(load_ready), 64'd1);
      check("cpu_rst_on_load", 64'(cpu_rst), 64'd1);
      check("done_on_load", 64'(done), 64'd0);
      check("error_on_load", 64'(error), 64'd0);
      for (int i = 0; i < n; i++) begin
         gap = (i == 0) ? 0 : ((maxGap >= 0) ? int'($urandom_range(0, maxGap)) : -maxGap);
         sum = sum + words[i];
         expA.push_back(ADDR_W'(i));
         expD.push_back(words[i]);
`ifdef MIPS_BOOT_CHECKSUM_EN
         sendWord(words[i], 1'b0, gap);
`else
         sendWord(words[i], (i == n - 1), gap);
`endif
      end
`ifdef MIPS_BOOT_CHECKSUM_EN
      sendWord(badSum ? sum + 32'd1 : sum, 1'b1, 0);
`endif
      load_valid = 1'b0;
      load_last  = 1'b0;
      settled = 1'b0;
      for (int t = 0; t < 40 && !settled; t++) begin
         @(negedge clk_CPU);
         settled = (done === 1'b1) || (error === 1'b1);
      end
      #1;
      check("settle", 64'(settled), 64'd1);
      check("done", 64'(done), 64'(!badSum));
      check("error", 64'(error), 64'(badSum));
      check("cpu_rst", 64'(cpu_rst), 64'(badSum));
      check("word_count", 64'(word_count), 64'(n));
      check("queue_drained", 64'(expA.size()), 64'd0);
`ifndef MIPS_BOOT_CHECKSUM_EN
      check("release_delay", 64'(fallCyc - lastWeCyc), 64'(RST_HOLD + 1));
`endif
   endtask

   initial begin
      logic [DATA_W-1:0] q[$];
      logic [DATA_W-1:0] w;
      int n;

      // Reset state and IDLE ignoring load_valid
      #12;
      check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("rst_ready", 64'(load_ready), 64'd0);
      check("rst_we", 64'(mem_we), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_wc", 64'(word_count), 64'd0);
      @(negedge clk_CPU);
      rst = 1'b0;
      load_valid = 1'b1;
      repeat (3) begin
         @(negedge clk_CPU);
         check("idle_ready", 64'(load_ready), 64'd0);
      end
      load_valid = 1'b0;
      @(posedge clk_CPU); #1;

      // Basic load, then reload from RUN with a single word
      q = '{32'h20080005, 32'h20090007, 32'h01095020};
      runLoad(q, 0, 1'b0);
      q = '{32'($urandom)};
      runLoad(q, 0, 1'b0);

      // Stall: two idle cycles between two words
      q = '{32'($urandom), 32'($urandom)};
      runLoad(q, -2, 1'b0);

      // Overflow: DEPTH words without last
      pulseStart();
      for (int i = 0; i < DEPTH; i++) begin
         w = $urandom;
         expA.push_back(ADDR_W'(i));
         expD.push_back(w);
         sendWord(w, 1'b0, 0);
      end
      load_valid = 1'b0;
      check("ovf_error", 64'(error), 64'd1);
      check("ovf_cpu_rst", 64'(cpu_rst), 64'd1);
      check("ovf_ready", 64'(load_ready), 64'd0);
      check("ovf_wc", 64'(word_count), 64'(DEPTH));
      @(negedge clk_CPU);
      @(posedge clk_CPU); #1;
      pulseStart();
      check("ovf_restart_error", 64'(error), 64'd0);
      check("ovf_restart_ready", 64'(load_ready), 64'd1);
      // start is ignored while already in LOAD
      q = '{32'($urandom)};
      runLoad(q, 0, 1'b0);

      // Asynchronous reset after 2 of 5 words
      pulseStart();
      for (int i = 0; i < 2; i++) begin
         w = $urandom;
         expA.push_back(ADDR_W'(i));
         expD.push_back(w);
         sendWord(w, 1'b0, 0);
      end
      load_valid = 1'b0;
      @(negedge clk_CPU);
      #2 rst = 1'b1;
      #1;
      check("arst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("arst_ready", 64'(load_ready), 64'd0);
      check("arst_we", 64'(mem_we), 64'd0);
      check("arst_addr", 64'(mem_addr), 64'd0);
      check("arst_wdata", 64'(mem_wdata), 64'd0);
      check("arst_wc", 64'(word_count), 64'd0);
      @(negedge clk_CPU);
      rst = 1'b0;
      load_valid = 1'b1;
      repeat (4) begin
         @(negedge clk_CPU);
         check("arst_idle_ready", 64'(load_ready), 64'd0);
      end
      load_valid = 1'b0;
      check("arst_idle_wc", 64'(word_count), 64'd0);
      @(posedge clk_CPU); #1;

`ifdef MIPS_BOOT_CHECKSUM_EN
      q = '{32'h00000001, 32'h00000002};
      runLoad(q, 0, 1'b0);
      runLoad(q, 0, 1'b1);
`endif

      // Randomized loads
      for (int r = 0; r < 20; r++) begin
         q = {};
`ifdef MIPS_BOOT_CHECKSUM_EN
         n = $urandom_range(0, DEPTH - 1);
`else
         n = $urandom_range(1, DEPTH);
`endif
         for (int i = 0; i < n; i++) q.push_back(32'($urandom));
`ifdef MIPS_BOOT_CHECKSUM_EN
         runLoad(q, 2, ($urandom_range(0, 2) == 0));
`else
         runLoad(q, 2, 1'b0);
`endif
      end

      check("final_queue_empty", 64'(expA.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000 time units");
      $fatal(1);
   end

endmodule
`default_nettype wire
